// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame controller.
// The CHK state only exists when UART_CMD_CHKSUM_EN is defined.
package uart_cmd_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LEN   = 3'd2,
        ST_DATA  = 3'd3,
`ifdef UART_CMD_CHKSUM_EN
        ST_CHK   = 3'd4,
`endif
        ST_FLUSH = 3'd5
    } state_e;

    function automatic logic len_ok(input logic [7:0] len, input logic [7:0] max_len);
        return (len != 8'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload buffer: one write port, one asynchronous read port, indexed by byte position.
module uart_cmd_buf
    import uart_cmd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [7:0]    wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command-frame controller: header/addr/len/payload[/checksum] framing, then a
// ready/valid burst of register writes. Define UART_CMD_CHKSUM_EN to require the checksum byte.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] HEADER       = HEADER_DEFAULT,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 20000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ready,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int             IW         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int             TW         = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]     MAX_LEN_B  = 8'(MAX_LEN);

    state_e        state_q, state_d;
    logic          rx_done_q, rx_done_prev_q;
    logic [7:0]    rx_data_q;
    logic [7:0]    base_q, base_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          wr_en_q, wr_en_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d;
    logic [1:0]    err_code_q, err_code_d;
`ifdef UART_CMD_CHKSUM_EN
    logic [7:0]    sum_q, sum_d;
`endif

    logic          byte_stb;
    logic          buf_we;
    logic [IW-1:0] rd_idx;
    logic [7:0]    rd_data;
    logic          start_flush;
    logic [7:0]    first_data;
    logic          timed;

    // One byte per rx_done rising edge, however long the level is held.
    assign byte_stb = rx_done_q && !rx_done_prev_q;
    assign rd_idx   = (state_q == ST_FLUSH) ? idx_q[IW-1:0] : '0;

    uart_cmd_buf #(
        .DEPTH (MAX_LEN),
        .IW    (IW)
    ) u_buf (
        .clk     (sys_clk),
        .wr_en   (buf_we),
        .wr_idx  (idx_q[IW-1:0]),
        .wr_data (rx_data_q),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        wr_en_d      = wr_en_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;
        buf_we       = 1'b0;
        start_flush  = 1'b0;
        first_data   = rd_data;
        timed        = 1'b0;
`ifdef UART_CMD_CHKSUM_EN
        sum_d        = sum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
`ifdef UART_CMD_CHKSUM_EN
                sum_d   = '0;
`endif
                if (byte_stb && rx_data_q == HEADER) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                timed = 1'b1;
                if (byte_stb) begin
                    base_d  = rx_data_q;
`ifdef UART_CMD_CHKSUM_EN
                    sum_d   = rx_data_q;
`endif
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                timed = 1'b1;
                if (byte_stb) begin
                    if (len_ok(rx_data_q, MAX_LEN_B)) begin
                        len_d   = rx_data_q;
                        idx_d   = '0;
`ifdef UART_CMD_CHKSUM_EN
                        sum_d   = sum_q + rx_data_q;
`endif
                        state_d = ST_DATA;
                    end else begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                    end
                end
            end
            ST_DATA: begin
                timed = 1'b1;
                if (byte_stb) begin
                    buf_we = 1'b1;
                    idx_d  = idx_q + 8'd1;
`ifdef UART_CMD_CHKSUM_EN
                    sum_d  = sum_q + rx_data_q;
                    if (idx_q == len_q - 8'd1) begin
                        state_d = ST_CHK;
                    end
`else
                    if (idx_q == len_q - 8'd1) begin
                        start_flush = 1'b1;
                        // A one-byte payload is still in flight to the buffer this cycle.
                        if (idx_q == 8'd0) begin
                            first_data = rx_data_q;
                        end
                    end
`endif
                end
            end
`ifdef UART_CMD_CHKSUM_EN
            ST_CHK: begin
                timed = 1'b1;
                if (byte_stb) begin
                    if (rx_data_q == sum_q) begin
                        start_flush = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                    end
                end
            end
`endif
            ST_FLUSH: begin
                if (wr_en_q && wr_ready) begin
                    if (idx_q == len_q) begin
                        wr_en_d      = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        wr_addr_d = base_q + idx_q;
                        wr_data_d = rd_data;
                        idx_d     = idx_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A byte landing in the expiry cycle keeps the frame alive.
        if (timed) begin
            if (byte_stb) begin
                timer_d = '0;
            end else if (timer_q == TIMER_LAST) begin
                timer_d     = '0;
                state_d     = ST_IDLE;
                frame_err_d = 1'b1;
                err_code_d  = ERR_TIMEOUT;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        if (start_flush) begin
            state_d   = ST_FLUSH;
            wr_en_d   = 1'b1;
            wr_addr_d = base_q;
            wr_data_d = first_data;
            idx_d     = 8'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= ST_IDLE;
            rx_done_q      <= 1'b0;
            rx_done_prev_q <= 1'b0;
            rx_data_q      <= '0;
            base_q         <= '0;
            len_q          <= '0;
            idx_q          <= '0;
            timer_q        <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            frame_done_q   <= 1'b0;
            frame_err_q    <= 1'b0;
            err_code_q     <= ERR_NONE;
`ifdef UART_CMD_CHKSUM_EN
            sum_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            rx_done_q      <= rx_done;
            rx_done_prev_q <= rx_done_q;
            rx_data_q      <= rx_data;
            base_q         <= base_d;
            len_q          <= len_d;
            idx_q          <= idx_d;
            timer_q        <= timer_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            frame_done_q   <= frame_done_d;
            frame_err_q    <= frame_err_d;
            err_code_q     <= err_code_d;
`ifdef UART_CMD_CHKSUM_EN
            sum_q          <= sum_d;
`endif
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frame table plus timeout, stall and reset sequences.
// Checksum bytes are sent only when UART_CMD_CHKSUM_EN is defined.
module tb_uart_cmd_ctrl;

    localparam int T = 1000;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       rx_done   = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic       wr_ready  = 1'b1;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    uart_cmd_ctrl #(
        .HEADER       (8'hA5),
        .MAX_LEN      (16),
        .TIMEOUT_CLKS (T)
    ) dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // wr_ready: constant 1, or a repeating 1-0-0-1 pattern.
    bit         rdy_toggle = 1'b0;
    logic [3:0] rdy_pat    = 4'b1001;
    int         rdy_ph     = 0;
    always @(posedge clk) begin
        #1;
        wr_ready = rdy_toggle ? rdy_pat[rdy_ph] : 1'b1;
        rdy_ph   = (rdy_ph + 1) % 4;
    end

    // Monitor: records handshakes and pulses, checks stall stability.
    logic [7:0] wq_addr[$];
    logic [7:0] wq_data[$];
    int         wq_cyc[$];
    int         n_done = 0, n_err = 0, done_cyc = 0, cyc = 0;
    logic [1:0] err_seen = 2'd0;
    bit         prev_stall = 1'b0;
    logic [7:0] st_addr = 8'h00, st_data = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!wr_en || wr_addr != st_addr || wr_data != st_data) begin
                    failures++;
                    $display("FAIL stall_hold: got en=%0b %h/%h, want en=1 %h/%h",
                             wr_en, wr_addr, wr_data, st_addr, st_data);
                end
            end
            if (wr_en && wr_ready) begin
                wq_addr.push_back(wr_addr);
                wq_data.push_back(wr_data);
                wq_cyc.push_back(cyc);
            end
            if (frame_done) begin n_done++; done_cyc = cyc; end
            if (frame_err)  begin n_err++;  err_seen = err_code; end
            if (frame_done || frame_err) begin
                checks++;
                if (frame_done && frame_err) begin
                    failures++;
                    $display("FAIL pulse_excl: frame_done and frame_err both high");
                end
            end
            prev_stall = wr_en && !wr_ready;
            st_addr    = wr_addr;
            st_data    = wr_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) @(posedge clk);
        #1 rx_done = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic wait_end(input int budget);
        int c;
        c = 0;
        while ((n_done + n_err) == 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        chk("end_seen", ((n_done + n_err) != 0), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_writes(input string tag, input int n, input logic [15:0][7:0] ea,
                              input logic [15:0][7:0] ed, input bit consec);
        chk($sformatf("%s_nwr", tag), wq_addr.size(), n);
        for (int k = 0; k < n && k < wq_addr.size(); k++) begin
            chk($sformatf("%s_addr%0d", tag, k), wq_addr[k], ea[k]);
            chk($sformatf("%s_data%0d", tag, k), wq_data[k], ed[k]);
            if (consec && k > 0) chk($sformatf("%s_consec%0d", tag, k), wq_cyc[k] - wq_cyc[k-1], 1);
        end
        if (n_done != 0 && wq_cyc.size() > 0)
            chk($sformatf("%s_done_lat", tag), done_cyc - wq_cyc[wq_cyc.size()-1], 1);
    endtask

    // Vector table
    typedef struct packed {
        logic [23:0][7:0] bytes;
        logic [7:0]       nbytes;
        logic [15:0][7:0] exp_addr;
        logic [15:0][7:0] exp_data;
        logic [7:0]       exp_nwr;
        logic             exp_done;
        logic             exp_err;
        logic [1:0]       exp_code;
    } vec_t;

    vec_t vecs [8];
    vec_t cur;
    int   nv = 0;

    task automatic begin_vec(input logic d, input logic e, input logic [1:0] c);
        cur          = '0;
        cur.exp_done = d;
        cur.exp_err  = e;
        cur.exp_code = c;
    endtask
    task automatic vb(input logic [7:0] b);
        cur.bytes[cur.nbytes] = b;
        cur.nbytes = cur.nbytes + 8'd1;
    endtask
    task automatic vw(input logic [7:0] a, input logic [7:0] d);
        cur.exp_addr[cur.exp_nwr] = a;
        cur.exp_data[cur.exp_nwr] = d;
        cur.exp_nwr = cur.exp_nwr + 8'd1;
    endtask
    task automatic end_vec();
        vecs[nv] = cur;
        nv++;
    endtask

    logic [1:0]       hold_code;
    logic [15:0][7:0] ea, ed;

    initial begin
        // Basic two-byte frame: sum 10+02+33+44 = 89
        begin_vec(1, 0, 0); vb(8'hA5); vb(8'h10); vb(8'h02); vb(8'h33); vb(8'h44);
`ifdef UART_CMD_CHKSUM_EN
        vb(8'h89);
`endif
        vw(8'h10, 8'h33); vw(8'h11, 8'h44); end_vec();
`ifdef UART_CMD_CHKSUM_EN
        begin_vec(0, 1, 2); vb(8'hA5); vb(8'h10); vb(8'h02); vb(8'h33); vb(8'h44); vb(8'h48); end_vec();
`endif
        begin_vec(0, 1, 1); vb(8'hA5); vb(8'h20); vb(8'h00); end_vec();
        begin_vec(0, 1, 1); vb(8'hA5); vb(8'h20); vb(8'h11); end_vec();
        // Leading junk byte ignored: sum 10+01+55 = 66
        begin_vec(1, 0, 0); vb(8'h00); vb(8'hA5); vb(8'h10); vb(8'h01); vb(8'h55);
`ifdef UART_CMD_CHKSUM_EN
        vb(8'h66);
`endif
        vw(8'h10, 8'h55); end_vec();
        // Address wrap: sum FE+03+01+02+03 = 07
        begin_vec(1, 0, 0); vb(8'hA5); vb(8'hFE); vb(8'h03); vb(8'h01); vb(8'h02); vb(8'h03);
`ifdef UART_CMD_CHKSUM_EN
        vb(8'h07);
`endif
        vw(8'hFE, 8'h01); vw(8'hFF, 8'h02); vw(8'h00, 8'h03); end_vec();
        // Max length: sum 40+10+(0..15) = C8
        begin_vec(1, 0, 0); vb(8'hA5); vb(8'h40); vb(8'h10);
        for (int i = 0; i < 16; i++) begin
            vb(8'(i));
            vw(8'(8'h40 + i), 8'(i));
        end
`ifdef UART_CMD_CHKSUM_EN
        vb(8'hC8);
`endif
        end_vec();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        hold_code = 2'd0;

        for (int v = 0; v < nv; v++) begin
            clear_mon();
            for (int b = 0; b < int'(vecs[v].nbytes); b++) send_byte(vecs[v].bytes[b], 3, 3);
            wait_end(300);
            chk($sformatf("v%0d_done", v), n_done, 32'(vecs[v].exp_done));
            chk($sformatf("v%0d_err", v), n_err, 32'(vecs[v].exp_err));
            if (vecs[v].exp_err) begin
                hold_code = vecs[v].exp_code;
                chk($sformatf("v%0d_code_pulse", v), err_seen, vecs[v].exp_code);
            end
            chk($sformatf("v%0d_code_hold", v), err_code, hold_code);
            chk($sformatf("v%0d_busy", v), busy, 0);
            chk_writes($sformatf("v%0d", v), int'(vecs[v].exp_nwr), vecs[v].exp_addr, vecs[v].exp_data, 1'b1);
            $display("vector %0d: bytes=%0d writes=%0d done=%0d err=%0d code=%0d",
                     v, vecs[v].nbytes, wq_addr.size(), n_done, n_err, err_code);
        end

        // Timeout: A5 30 then silence
        clear_mon();
        send_byte(8'hA5, 3, 3);
        @(posedge clk); #1 rx_data = 8'h30; rx_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 rx_done = 1'b0;
        repeat (T - 1) @(posedge clk);
        #1 chk("tmo_early", frame_err, 0);
        @(posedge clk);
        #1 chk("tmo_pulse", frame_err, 1);
        chk("tmo_code", err_code, 3);
        chk("tmo_busy", busy, 0);
        hold_code = 2'd3;
        repeat (3) @(posedge clk);
        chk("tmo_nerr", n_err, 1);
        $display("timeout: err=%0d code=%0d", n_err, err_code);

        // Byte arriving in the exact timeout cycle keeps the frame alive
        clear_mon();
        send_byte(8'hA5, 3, 3);
        @(posedge clk); #1 rx_data = 8'h30; rx_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 rx_done = 1'b0;
        repeat (T - 2) @(posedge clk);
        #1 rx_data = 8'h01; rx_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("race_no_err", frame_err, 0);
        chk("race_busy", busy, 1);
        rx_done = 1'b0;
        send_byte(8'h77, 3, 3);
`ifdef UART_CMD_CHKSUM_EN
        send_byte(8'hA8, 3, 3);
`endif
        wait_end(300);
        chk("race_done", n_done, 1);
        chk("race_nerr", n_err, 0);
        chk("race_code_hold", err_code, hold_code);
        ea = '0; ed = '0; ea[0] = 8'h30; ed[0] = 8'h77;
        chk_writes("race", 1, ea, ed, 1'b0);
        $display("race: writes=%0d done=%0d err=%0d", wq_addr.size(), n_done, n_err);

        // Wrap with stalled wr_ready and long rx_done levels
        clear_mon();
        rdy_toggle = 1'b1;
        send_byte(8'hA5, 200, 2);
        send_byte(8'hFE, 200, 2);
        send_byte(8'h03, 200, 2);
        send_byte(8'h01, 200, 2);
        send_byte(8'h02, 200, 2);
        send_byte(8'h03, 200, 2);
`ifdef UART_CMD_CHKSUM_EN
        send_byte(8'h07, 200, 2);
`endif
        wait_end(300);
        rdy_toggle = 1'b0;
        chk("stall_done", n_done, 1);
        chk("stall_nerr", n_err, 0);
        ea = '0; ed = '0;
        ea[0] = 8'hFE; ed[0] = 8'h01;
        ea[1] = 8'hFF; ed[1] = 8'h02;
        ea[2] = 8'h00; ed[2] = 8'h03;
        chk_writes("stall", 3, ea, ed, 1'b0);
        $display("stall: writes=%0d done=%0d err=%0d", wq_addr.size(), n_done, n_err);

        // Reset during DATA, then a fresh frame
        clear_mon();
        send_byte(8'hA5, 3, 3);
        send_byte(8'h50, 3, 3);
        send_byte(8'h04, 3, 3);
        send_byte(8'h11, 3, 3);
        send_byte(8'h22, 3, 3);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("rst_mid_busy", busy, 0);
        chk("rst_mid_wr_en", wr_en, 0);
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        chk("rst_mid_nwr", wq_addr.size(), 0);
        chk("rst_mid_done", n_done, 0);
        chk("rst_mid_err", n_err, 0);
        chk("rst_mid_code", err_code, 0);
        send_byte(8'hA5, 3, 3);
        send_byte(8'h60, 3, 3);
        send_byte(8'h01, 3, 3);
        send_byte(8'h99, 3, 3);
`ifdef UART_CMD_CHKSUM_EN
        send_byte(8'hFA, 3, 3);
`endif
        wait_end(300);
        chk("post_rst_done", n_done, 1);
        chk("post_rst_err", n_err, 0);
        ea = '0; ed = '0; ea[0] = 8'h60; ed[0] = 8'h99;
        chk_writes("post_rst", 1, ea, ed, 1'b0);
        $display("reset: writes=%0d done=%0d err=%0d", wq_addr.size(), n_done, n_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got no end of test, want end before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
